// File: rtl/hilo_commit.sv
// MEM/WB pipeline tail for the execute result bus: stages GPR and HI/LO writes under
// stall/flush control, commits HI/LO in WB and exposes both stages as forwarding buses.
module hilo_commit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [DATA_W-1:0] ex_hi_i,
    input  logic [DATA_W-1:0] ex_lo_i,
    input  logic              ex_whilo_i,

    input  logic [1:0]        stall_i,
    input  logic              flush_i,

    output logic [ADDR_W-1:0] mem_wd_o,
    output logic              mem_wreg_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [DATA_W-1:0] mem_hi_o,
    output logic [DATA_W-1:0] mem_lo_o,
    output logic              mem_whilo_o,

    output logic [ADDR_W-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [DATA_W-1:0] wb_hi_o,
    output logic [DATA_W-1:0] wb_lo_o,
    output logic              wb_whilo_o,

    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [15:0]       commit_cnt_o
);

    // MEM stage registers
    logic [ADDR_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_wreg_q, mem_wreg_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] mem_hi_q, mem_hi_d;
    logic [DATA_W-1:0] mem_lo_q, mem_lo_d;
    logic              mem_whilo_q, mem_whilo_d;

    // WB stage registers
    logic [ADDR_W-1:0] wb_wd_q, wb_wd_d;
    logic              wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic [DATA_W-1:0] wb_hi_q, wb_hi_d;
    logic [DATA_W-1:0] wb_lo_q, wb_lo_d;
    logic              wb_whilo_q, wb_whilo_d;

    // Committed HI/LO and commit counter
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              commit_en;

    // stall 2'b10 behaves like 2'b11 because any set bit holds MEM
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        if (flush_i) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
        end else if (stall_i == 2'b00) begin
            mem_wd_d    = ex_wd_i;
            mem_wreg_d  = ex_wreg_i;
            mem_wdata_d = ex_wdata_i;
            mem_hi_d    = ex_hi_i;
            mem_lo_d    = ex_lo_i;
            mem_whilo_d = ex_whilo_i;
        end
    end

    // A bubble enters WB when only MEM is held, so the held entry is not duplicated
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        wb_hi_d    = wb_hi_q;
        wb_lo_d    = wb_lo_q;
        wb_whilo_d = wb_whilo_q;
        if (flush_i || (!stall_i[1] && stall_i[0])) begin
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
            wb_hi_d    = '0;
            wb_lo_d    = '0;
            wb_whilo_d = 1'b0;
        end else if (!stall_i[1]) begin
            wb_wd_d    = mem_wd_q;
            wb_wreg_d  = mem_wreg_q;
            wb_wdata_d = mem_wdata_q;
            wb_hi_d    = mem_hi_q;
            wb_lo_d    = mem_lo_q;
            wb_whilo_d = mem_whilo_q;
        end
    end

    // Flush does not block the commit: the WB entry retires on the flushing edge
    assign commit_en = wb_whilo_q & ~stall_i[1];

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (commit_en) begin
            hi_d  = wb_hi_q;
            lo_d  = wb_lo_q;
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_hi_q    <= '0;
            mem_lo_q    <= '0;
            mem_whilo_q <= 1'b0;
            wb_wd_q     <= '0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= '0;
            wb_hi_q     <= '0;
            wb_lo_q     <= '0;
            wb_whilo_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_hi_q    <= mem_hi_d;
            mem_lo_q    <= mem_lo_d;
            mem_whilo_q <= mem_whilo_d;
            wb_wd_q     <= wb_wd_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wdata_q  <= wb_wdata_d;
            wb_hi_q     <= wb_hi_d;
            wb_lo_q     <= wb_lo_d;
            wb_whilo_q  <= wb_whilo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd_o     = mem_wd_q;
    assign mem_wreg_o   = mem_wreg_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_hi_o     = mem_hi_q;
    assign mem_lo_o     = mem_lo_q;
    assign mem_whilo_o  = mem_whilo_q;
    assign wb_wd_o      = wb_wd_q;
    assign wb_wreg_o    = wb_wreg_q;
    assign wb_wdata_o   = wb_wdata_q;
    assign wb_hi_o      = wb_hi_q;
    assign wb_lo_o      = wb_lo_q;
    assign wb_whilo_o   = wb_whilo_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign commit_cnt_o = cnt_q;

endmodule

// File: tb/tb_hilo_commit.sv
// Directed bench for hilo_commit: latency, stalls, flush, GPR pass-through, async reset, wrap.
module tb_hilo_commit;

    logic        clk;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [1:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [15:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    hilo_commit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wd_i      (ex_wd),
        .ex_wreg_i    (ex_wreg),
        .ex_wdata_i   (ex_wdata),
        .ex_hi_i      (ex_hi),
        .ex_lo_i      (ex_lo),
        .ex_whilo_i   (ex_whilo),
        .stall_i      (stall),
        .flush_i      (flush),
        .mem_wd_o     (mem_wd),
        .mem_wreg_o   (mem_wreg),
        .mem_wdata_o  (mem_wdata),
        .mem_hi_o     (mem_hi),
        .mem_lo_o     (mem_lo),
        .mem_whilo_o  (mem_whilo),
        .wb_wd_o      (wb_wd),
        .wb_wreg_o    (wb_wreg),
        .wb_wdata_o   (wb_wdata),
        .wb_hi_o      (wb_hi),
        .wb_lo_o      (wb_lo),
        .wb_whilo_o   (wb_whilo),
        .hi_o         (hi),
        .lo_o         (lo),
        .commit_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_wd    = '0;
        ex_wreg  = 1'b0;
        ex_wdata = '0;
        ex_hi    = '0;
        ex_lo    = '0;
        ex_whilo = 1'b0;
        stall    = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic drive_hilo(input logic [31:0] h, input logic [31:0] l);
        drive_idle();
        ex_hi    = h;
        ex_lo    = l;
        ex_whilo = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_cmp++;
        if ({mem_whilo, mem_wreg, wb_whilo, wb_wreg, hi, lo, cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: hi=%h lo=%h cnt=%h mem_whilo=%b wb_whilo=%b, want all 0",
                     hi, lo, cnt, mem_whilo, wb_whilo);
        end
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic test_latency();
        drive_hilo(32'h1234_5678, 32'h9ABC_DEF0);
        step();
        drive_idle();
        n_cmp++;
        if ({mem_whilo, mem_hi, mem_lo} !== {1'b1, 32'h1234_5678, 32'h9ABC_DEF0}) begin
            n_err++;
            $display("FAIL lat_mem: whilo=%b hi=%h lo=%h, want 1 12345678 9abcdef0",
                     mem_whilo, mem_hi, mem_lo);
        end
        step();
        n_cmp++;
        if ({wb_whilo, wb_hi, wb_lo, hi} !== {1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0}) begin
            n_err++;
            $display("FAIL lat_wb: whilo=%b hi=%h lo=%h hi_o=%h, want 1 12345678 9abcdef0 0",
                     wb_whilo, wb_hi, wb_lo, hi);
        end
        step();
        n_cmp++;
        if ({hi, lo, cnt} !== {32'h1234_5678, 32'h9ABC_DEF0, 16'd1}) begin
            n_err++;
            $display("FAIL lat_commit: hi=%h lo=%h cnt=%0d, want 12345678 9abcdef0 1", hi, lo, cnt);
        end
    endtask

    // A then B back to back; MEM held on B for 2 cycles (cnt enters at 1)
    task automatic test_stall_mem();
        drive_hilo(32'hAAAA_0001, 32'hAAAA_0002);
        step();
        drive_hilo(32'hBBBB_0001, 32'hBBBB_0002);
        step();
        drive_idle();
        stall = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({mem_whilo, mem_hi, wb_whilo} !== {1'b1, 32'hBBBB_0001, 1'b0}) begin
                n_err++;
                $display("FAIL stall01_hold[%0d]: mem_whilo=%b mem_hi=%h wb_whilo=%b, want 1 bbbb0001 0",
                         i, mem_whilo, mem_hi, wb_whilo);
            end
        end
        n_cmp++;
        if ({hi, cnt} !== {32'hAAAA_0001, 16'd2}) begin
            n_err++;
            $display("FAIL stall01_a_commit: hi=%h cnt=%0d, want aaaa0001 2", hi, cnt);
        end
        stall = 2'b00;
        step();
        n_cmp++;
        if ({mem_whilo, wb_whilo, wb_hi} !== {1'b0, 1'b1, 32'hBBBB_0001}) begin
            n_err++;
            $display("FAIL stall01_release: mem_whilo=%b wb_whilo=%b wb_hi=%h, want 0 1 bbbb0001",
                     mem_whilo, wb_whilo, wb_hi);
        end
        step();
        step();
        n_cmp++;
        if ({hi, lo, cnt} !== {32'hBBBB_0001, 32'hBBBB_0002, 16'd3}) begin
            n_err++;
            $display("FAIL stall01_b_once: hi=%h lo=%h cnt=%0d, want bbbb0001 bbbb0002 3", hi, lo, cnt);
        end
    endtask

    // C in WB, D in MEM, both held 3 cycles (cnt enters at 3)
    task automatic test_stall_both();
        drive_hilo(32'hCCCC_0001, 32'hCCCC_0002);
        step();
        drive_hilo(32'hDDDD_0001, 32'hDDDD_0002);
        step();
        drive_idle();
        stall = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({mem_hi, mem_whilo, wb_hi, wb_whilo, hi, cnt} !==
                {32'hDDDD_0001, 1'b1, 32'hCCCC_0001, 1'b1, 32'hBBBB_0001, 16'd3}) begin
                n_err++;
                $display("FAIL stall11_hold[%0d]: mem_hi=%h wb_hi=%h hi=%h cnt=%0d, want dddd0001 cccc0001 bbbb0001 3",
                         i, mem_hi, wb_hi, hi, cnt);
            end
        end
        stall = 2'b00;
        step();
        n_cmp++;
        if ({hi, cnt, wb_hi} !== {32'hCCCC_0001, 16'd4, 32'hDDDD_0001}) begin
            n_err++;
            $display("FAIL stall11_release: hi=%h cnt=%0d wb_hi=%h, want cccc0001 4 dddd0001", hi, cnt, wb_hi);
        end
        step();
        n_cmp++;
        if ({hi, cnt} !== {32'hDDDD_0001, 16'd5}) begin
            n_err++;
            $display("FAIL stall11_next: hi=%h cnt=%0d, want dddd0001 5", hi, cnt);
        end
    endtask

    // E in WB, F in MEM, flush: E commits, F dropped (cnt enters at 5)
    task automatic test_flush();
        drive_hilo(32'hEEEE_0001, 32'hEEEE_0002);
        step();
        drive_hilo(32'hFFFF_0001, 32'hFFFF_0002);
        step();
        drive_idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if ({hi, lo, cnt, mem_whilo, mem_hi, wb_whilo, wb_hi} !==
            {32'hEEEE_0001, 32'hEEEE_0002, 16'd6, 1'b0, 32'h0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL flush_edge: hi=%h lo=%h cnt=%0d mem_whilo=%b wb_whilo=%b, want eeee0001 eeee0002 6 0 0",
                     hi, lo, cnt, mem_whilo, wb_whilo);
        end
        step();
        step();
        n_cmp++;
        if ({hi, cnt} !== {32'hEEEE_0001, 16'd6}) begin
            n_err++;
            $display("FAIL flush_no_f: hi=%h cnt=%0d, want eeee0001 6", hi, cnt);
        end
    endtask

    task automatic test_gpr();
        drive_idle();
        ex_wd    = 5'd9;
        ex_wreg  = 1'b1;
        ex_wdata = 32'hDEAD_BEEF;
        step();
        drive_idle();
        n_cmp++;
        if ({mem_wd, mem_wreg, mem_wdata, mem_whilo} !== {5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL gpr_mem: wd=%0d wreg=%b wdata=%h, want 9 1 deadbeef", mem_wd, mem_wreg, mem_wdata);
        end
        step();
        n_cmp++;
        if ({wb_wd, wb_wreg, wb_wdata, wb_whilo} !== {5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_err++;
            $display("FAIL gpr_wb: wd=%0d wreg=%b wdata=%h, want 9 1 deadbeef", wb_wd, wb_wreg, wb_wdata);
        end
        step();
        n_cmp++;
        if ({hi, lo, cnt, wb_wreg} !== {32'hEEEE_0001, 32'hEEEE_0002, 16'd6, 1'b0}) begin
            n_err++;
            $display("FAIL gpr_no_commit: hi=%h lo=%h cnt=%0d wb_wreg=%b, want eeee0001 eeee0002 6 0",
                     hi, lo, cnt, wb_wreg);
        end
    endtask

    task automatic test_async_reset();
        drive_hilo(32'h1111_1111, 32'h2222_2222);
        ex_wreg = 1'b1;
        ex_wd   = 5'd3;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_wd, mem_wreg, mem_whilo, mem_hi, wb_wd, wb_wreg, wb_whilo, wb_hi, hi, lo, cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset: mem_hi=%h wb_hi=%h hi=%h lo=%h cnt=%0d, want all 0",
                     mem_hi, wb_hi, hi, lo, cnt);
        end
        drive_idle();
        release_reset();
    endtask

    // Continuous whilo stream: commits start on the 3rd edge, so 65537 edges -> 65535 commits
    task automatic test_wrap();
        drive_hilo(32'hCAFE_0000, 32'hF00D_0000);
        repeat (65537) step();
        drive_idle();
        n_cmp++;
        if ({cnt, hi, lo} !== {16'hFFFF, 32'hCAFE_0000, 32'hF00D_0000}) begin
            n_err++;
            $display("FAIL wrap_preload: cnt=%h hi=%h lo=%h, want ffff cafe0000 f00d0000", cnt, hi, lo);
        end
        step();
        n_cmp++;
        if (cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_rollover: cnt=%h, want 0000", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall_mem();
        test_stall_both();
        test_flush();
        test_gpr();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
